cache_nway_wb: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate LC-3b cache.
- Integrates tag/valid/dirty/data storage, true-LRU replacement and the control FSM in one block.
- Sits between the CPU memory port (16-bit words) and physical memory (128-bit lines).
- Successor to the fixed 2-way split datapath/control cache: way count and set count are generic, victim choice is first-invalid-then-LRU, and optional performance counters are available.

---
 rtl/cache_nway_wb_pkg.sv | 23 ++
 rtl/cache_nway_wb_lru_ages.sv | 41 ++++
 rtl/cache_nway_wb.sv | 162 ++++++++++++++++
 tb/tb_cache_nway_wb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_nway_wb_pkg.sv
// Shared LC-3b memory types, cache FSM states and word helpers for 128-bit lines.
// No state: pure types and combinational functions.
package lc3b_types;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_block;
  typedef logic [1:0]   lc3b_mem_wmask;
  typedef logic [2:0]   lc3b_word_sel;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} cache_state_t;

  function automatic lc3b_word block_word(input lc3b_block blk, input lc3b_word_sel sel);
    return blk[{sel, 4'b0000} +: 16];
  endfunction

  function automatic lc3b_block block_merge(input lc3b_block blk, input lc3b_word_sel sel,
                                            input lc3b_word wdata, input lc3b_mem_wmask be);
    lc3b_block r;
    r = blk;
    if (be[0]) r[{sel, 4'b0000} +: 8] = wdata[7:0];
    if (be[1]) r[{sel, 4'b1000} +: 8] = wdata[15:8];
    return r;
  endfunction
endpackage

// File: rtl/cache_nway_wb_lru_ages.sv
// True-LRU age array per set: hit way goes to age 0, younger ways age by one; victim is age WAYS-1.
// Registered update, combinational victim read; never stalls.
module cache_lru_ages #(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(SETS)-1:0] idx,
  input  logic                    upd,
  input  logic [$clog2(WAYS)-1:0] upd_way,
  output logic [$clog2(WAYS)-1:0] victim
);
  localparam int AGE_W = $clog2(WAYS);

  logic [AGE_W-1:0] age [SETS][WAYS];
  logic [AGE_W-1:0] hit_age;

  assign hit_age = age[idx][upd_way];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AGE_W'(w);
    end else if (upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == upd_way)
          age[idx][w] <= '0;
        else if (age[idx][w] < hit_age)
          age[idx][w] <= age[idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[idx][w] == AGE_W'(WAYS - 1)) victim = AGE_W'(w);
  end
endmodule

// File: rtl/cache_nway_wb.sv
// N-way write-back/write-allocate LC-3b cache; CACHE_PERF_CNT_EN enables hit/miss counters.
// Hit responds 1 cycle after IDLE sees the request; misses add write-back/fill latency; CPU and pmem requests are level-held.
module cache_nway_wb
  import lc3b_types::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  output logic [127:0]  pmem_wdata,
  input  logic [127:0]  pmem_rdata,
  input  logic          pmem_resp,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 12 - IDX_W;
  localparam int WAY_W = $clog2(WAYS);

  cache_state_t     state;
  logic [WAY_W-1:0] victim, victim_c, lru_way, hit_way;
  logic             hit, lru_upd;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  lc3b_word_sel     word_sel;
  logic             unused_bit;

  logic             valid [SETS][WAYS];
  logic             dirty [SETS][WAYS];
  logic [TAG_W-1:0] tags  [SETS][WAYS];
  lc3b_block        data  [SETS][WAYS];

  assign idx        = mem_address[4 +: IDX_W];
  assign tag        = mem_address[15 -: TAG_W];
  assign word_sel   = mem_address[3:1];
  assign unused_bit = mem_address[0];

  // Descending scan so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
  end

  always_comb begin
    victim_c = lru_way;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[idx][w]) victim_c = WAY_W'(w);
  end

  assign lru_upd   = (state == COMPARE) && hit;
  assign mem_resp  = lru_upd;
  assign mem_rdata = lru_upd ? block_word(data[idx][hit_way], word_sel) : '0;

  cache_lru_ages #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk     (clk),
    .reset   (reset),
    .idx     (idx),
    .upd     (lru_upd),
    .upd_way (hit_way),
    .victim  (lru_way)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      victim       <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid[s][w] <= 1'b0;
          dirty[s][w] <= 1'b0;
        end
    end else begin
      case (state)
        IDLE: if (mem_read || mem_write) state <= COMPARE;
        COMPARE: begin
          if (hit) begin
            state <= IDLE;
            if (mem_write && mem_byte_enable != 2'b00) dirty[idx][hit_way] <= 1'b1;
          end else begin
            victim <= victim_c;
            if (valid[idx][victim_c] && dirty[idx][victim_c]) begin
              state        <= WRITEBACK;
              pmem_write   <= 1'b1;
              pmem_address <= {tags[idx][victim_c], idx, 4'b0000};
              pmem_wdata   <= data[idx][victim_c];
            end else begin
              state        <= ALLOCATE;
              pmem_read    <= 1'b1;
              pmem_address <= {tag, idx, 4'b0000};
            end
          end
        end
        WRITEBACK: if (pmem_resp) begin
          state        <= ALLOCATE;
          pmem_write   <= 1'b0;
          pmem_read    <= 1'b1;
          pmem_address <= {tag, idx, 4'b0000};
        end
        ALLOCATE: if (pmem_resp) begin
          state                <= COMPARE;
          pmem_read            <= 1'b0;
          valid[idx][victim]   <= 1'b1;
          dirty[idx][victim]   <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == COMPARE && hit && mem_write)
        data[idx][hit_way] <= block_merge(data[idx][hit_way], word_sel, mem_wdata, mem_byte_enable);
      if (state == ALLOCATE && pmem_resp) begin
        data[idx][victim] <= pmem_rdata;
        tags[idx][victim] <= tag;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic filled;

  // filled marks the COMPARE that follows a fill so its completion is not counted as a hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      filled     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      filled <= (state == ALLOCATE && pmem_resp) || (filled && state != COMPARE);
      if (state == COMPARE && hit && !filled && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (state == COMPARE && !hit && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: tb/tb_cache_nway_wb.sv
// Randomized + directed bench for cache_nway_wb against a recency-stamp cache model and a backing-memory model.
// Scoreboard queues carry expected CPU responses and expected pmem transactions.
module tb_cache_nway_wb;
  localparam int WAYS = 2;
  localparam int SETS = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  cache_nway_wb #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct { bit chk; logic [15:0] rdata; } sb_t;
  typedef struct { bit is_wr; logic [15:0] addr; logic [127:0] data; } pop_t;

  sb_t  sbq[$];
  pop_t pq[$];
  int   checks = 0;
  int   failures = 0;

  logic [127:0] phys [logic [11:0]];
  logic [127:0] mmem [logic [11:0]];
  bit           m_valid [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  logic [11:0]  m_line  [SETS][WAYS];
  logic [127:0] m_data  [SETS][WAYS];
  int           m_stamp [SETS][WAYS];
  int           m_time = 0, m_hits = 0, m_miss = 0;

  int           fill_lat = 2;
  int           n_pwr = 0;
  logic [15:0]  last_rd = '0, last_wr = '0;
  logic [127:0] last_wr_data = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [127:0] init_line(input logic [11:0] la);
    logic [127:0] b;
    for (int w = 0; w < 8; w++)
      b[w*16 +: 16] = (16'(la) * 16'd40503 + 16'(w * 7919)) ^ 16'h5A5A;
    return b;
  endfunction

  function automatic logic [127:0] phys_get(input logic [11:0] la);
    if (phys.exists(la)) return phys[la];
    return init_line(la);
  endfunction

  function automatic logic [127:0] mmem_get(input logic [11:0] la);
    if (mmem.exists(la)) return mmem[la];
    return init_line(la);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    m_hits = 0;
    m_miss = 0;
  endtask

  // Cache as a set of resident lines; eviction picks an empty slot, else the least recently used.
  task automatic model_req(input bit wr, input logic [15:0] a, input logic [1:0] be,
                           input logic [15:0] wd, output bit was_hit, output logic [15:0] exp_rd);
    logic [11:0] la;
    int s, f, wi;
    pop_t op;
    la = a[15:4];
    s  = int'(a[6:4]);
    wi = int'(a[3:1]);
    f  = -1;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_line[s][w] == la) f = w;
    was_hit = (f >= 0);
    if (was_hit) m_hits++;
    else begin
      m_miss++;
      f = 0;
      for (int w = WAYS - 1; w >= 0; w--)
        if (m_valid[s][w] && m_valid[s][f] && m_stamp[s][w] < m_stamp[s][f]) f = w;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[s][w]) f = w;
      if (m_valid[s][f] && m_dirty[s][f]) begin
        op = '{1'b1, {m_line[s][f], 4'h0}, m_data[s][f]};
        pq.push_back(op);
        mmem[m_line[s][f]] = m_data[s][f];
      end
      op = '{1'b0, {la, 4'h0}, 128'h0};
      pq.push_back(op);
      m_valid[s][f] = 1'b1;
      m_dirty[s][f] = 1'b0;
      m_line[s][f]  = la;
      m_data[s][f]  = mmem_get(la);
    end
    m_time++;
    m_stamp[s][f] = m_time;
    exp_rd = m_data[s][f][wi*16 +: 16];
    if (wr) begin
      if (be[0]) m_data[s][f][wi*16 +: 8]     = wd[7:0];
      if (be[1]) m_data[s][f][wi*16 + 8 +: 8] = wd[15:8];
      if (be != 2'b00) m_dirty[s][f] = 1'b1;
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef CACHE_PERF_CNT_EN
    chk({tag, "_hit_count"}, hit_count, 16'(m_hits));
    chk({tag, "_miss_count"}, miss_count, 16'(m_miss));
`else
    chk({tag, "_hit_count"}, hit_count, 16'h0);
    chk({tag, "_miss_count"}, miss_count, 16'h0);
`endif
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a, input logic [1:0] be,
                        input logic [15:0] wd, output logic [15:0] got, output int lat);
    bit h;
    logic [15:0] e;
    sb_t sbe;
    model_req(wr, a, be, wd, h, e);
    sbe = '{!wr, e};
    sbq.push_back(sbe);
    mem_address = a; mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_wdata = wd;
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      if (mem_resp || lat > 300) break;
      lat++;
    end
    got = mem_rdata;
    if (lat > 300) begin
      checks++; failures++;
      $display("FAIL resp_timeout addr=%0h waited=%0d limit=300", a, lat);
      finish_run();
    end
    if (h) chk("hit_latency", 128'(lat), 128'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Scoreboard monitor: every CPU completion pops one expected response.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_resp) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL mon_unexpected_resp got=resp exp=none");
        end else begin
          e = sbq.pop_front();
          if (e.chk) chk("mon_rdata", mem_rdata, e.rdata);
        end
      end
    end
  end

  // Physical memory: checks each request against the expected queue, answers after fill_lat cycles.
  initial begin
    pop_t e;
    bit cur_wr;
    logic [15:0] a;
    logic [127:0] d;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!reset && (pmem_read || pmem_write)) begin
        cur_wr = pmem_write; a = pmem_address; d = pmem_wdata;
        if (pq.size() == 0) begin
          checks++; failures++;
          $display("FAIL pmem_unexpected got_addr=%0h got_wr=%0d exp=none", a, cur_wr);
        end else begin
          e = pq.pop_front();
          chk("pmem_is_write", 128'(cur_wr), 128'(e.is_wr));
          chk("pmem_address", a, e.addr);
          if (e.is_wr) chk("pmem_wdata", d, e.data);
        end
        if (cur_wr) begin
          phys[a[15:4]] = d; last_wr = a; last_wr_data = d; n_pwr++;
        end else last_rd = a;
        repeat (fill_lat) @(posedge clk);
        #1;
        pmem_rdata = cur_wr ? 128'h0 : phys_get(a[15:4]);
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
      end
    end
  end

  initial begin
    logic [15:0] got;
    logic [127:0] b;
    int lat, n, pw0;
    bit h;
    logic [15:0] e;

    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0;
    model_reset();
    b = init_line(12'h123);
    b[47:32] = 16'hBEEF;
    phys[12'h123] = b;
    mmem[12'h123] = b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk_cnt("rst");
    @(posedge clk); #1 reset = 1'b0;

    // 1: cold miss fill
    do_req(1, 0, 16'h1234, 2'b11, 16'h0, got, lat);
    chk("t1_rdata", got, 16'hBEEF);
    chk("t1_fill_addr", last_rd, 16'h1230);
    chk_cnt("t1");

    // 2: hit
    do_req(1, 0, 16'h1234, 2'b11, 16'h0, got, lat);
    chk("t2_rdata", got, 16'hBEEF);
    chk("t2_latency", 128'(lat), 128'd0);
    chk_cnt("t2");

    // 3: low-byte write then read back
    do_req(0, 1, 16'h1234, 2'b01, 16'hABCD, got, lat);
    do_req(1, 0, 16'h1234, 2'b11, 16'h0, got, lat);
    chk("t3_merged", got, 16'hBECD);

    // 4: dirty LRU eviction
    do_req(1, 0, 16'h1434, 2'b11, 16'h0, got, lat);
    pw0 = n_pwr;
    do_req(1, 0, 16'h1634, 2'b11, 16'h0, got, lat);
    chk("t4_wb_count", 128'(n_pwr - pw0), 128'd1);
    chk("t4_wb_addr", last_wr, 16'h1230);
    chk("t4_wb_word2", last_wr_data[47:32], 16'hBECD);
    chk("t4_fill_addr", last_rd, 16'h1630);

    // 5: reset while a fill is outstanding
    fill_lat = 20;
    model_req(0, 16'h1834, 2'b11, 16'h0, h, e);
    mem_address = 16'h1834; mem_read = 1'b1;
    n = 0;
    while (!pmem_read && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL t5_fill_timeout waited=%0d limit=100", n);
      finish_run();
    end
    @(posedge clk); #1;
    reset = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t5_pmem_read_dropped", pmem_read, 0);
    chk_cnt("t5_rst");
    fill_lat = 2;
    repeat (30) @(posedge clk);
    #1;
    chk("t5_late_resp_ignored", {pmem_read, pmem_write, mem_resp}, 3'b000);
    do_req(1, 0, 16'h1434, 2'b11, 16'h0, got, lat);
    chk("t5_miss_after_reset", 128'(lat > 0), 128'd1);
    chk("t5_refill_addr", last_rd, 16'h1430);

    // 6: empty byte-enable write leaves line clean
    do_req(0, 1, 16'h1434, 2'b00, 16'hFFFF, got, lat);
    pw0 = n_pwr;
    do_req(1, 0, 16'h1834, 2'b11, 16'h0, got, lat);
    do_req(1, 0, 16'h1A34, 2'b11, 16'h0, got, lat);
    chk("t6_no_writeback", 128'(n_pwr), 128'(pw0));
    chk("t6_fill_addr", last_rd, 16'h1A30);
    chk_cnt("t6");

    // Random traffic over a few conflicting tags in three sets
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      bit rd, wr;
      a = {9'h040 + 9'($urandom_range(0, 3)), 3'($urandom_range(0, 2)), 4'($urandom)};
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      fill_lat = $urandom_range(1, 4);
      do_req(rd, wr, a, 2'($urandom), 16'($urandom), got, lat);
    end

    repeat (5) @(posedge clk);
    chk("pmem_queue_drained", 128'(pq.size()), 128'd0);
    chk("sb_queue_drained", 128'(sbq.size()), 128'd0);
    chk_cnt("final");
    finish_run();
  end
endmodule
